// File: rtl/slice_pkg.sv
// Shared defaults, saturation limits and FSM state encoding for the sigma-delta filter slice.
package slice_pkg;
  localparam int DEF_DATA_W = 24;
  localparam int DEF_COEF_W = 18;

  function automatic logic signed [63:0] full_pos(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] full_neg(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  typedef enum logic [1:0] {CLEAR, IDLE, SWEEP, DRAIN} slice_state_e;
endpackage

// File: rtl/slice_sat_addsub.sv
// Four-operand signed add with per-coefficient sign control and overflow detect.
// Define SLICE_SAT_EN to clamp overflowed sums; otherwise they wrap to DATA_W bits.
module slice_sat_addsub
  import slice_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W
) (
  input  logic signed [DATA_W-1:0] prev,
  input  logic signed [DATA_W-1:0] st,
  input  logic signed [COEF_W-1:0] coef_a,
  input  logic signed [COEF_W-1:0] coef_b,
  input  logic                     add_a,
  input  logic                     add_b,
  output logic signed [DATA_W-1:0] res,
  output logic                     ovf
);
  localparam int ACC_W = DATA_W + 2;
  localparam logic signed [ACC_W-1:0] POS = ACC_W'(full_pos(DATA_W));
  localparam logic signed [ACC_W-1:0] NEG = ACC_W'(full_neg(DATA_W));

  logic signed [ACC_W-1:0] ep, es, ea, eb, acc;

  always_comb begin
    ep  = {{2{prev[DATA_W-1]}}, prev};
    es  = {{2{st[DATA_W-1]}}, st};
    ea  = {{(ACC_W-COEF_W){coef_a[COEF_W-1]}}, coef_a};
    eb  = {{(ACC_W-COEF_W){coef_b[COEF_W-1]}}, coef_b};
    acc = ep + es + (add_a ? ea : -ea) + (add_b ? eb : -eb);
    ovf = (acc > POS) || (acc < NEG);
`ifdef SLICE_SAT_EN
    if (acc > POS)      res = POS[DATA_W-1:0];
    else if (acc < NEG) res = NEG[DATA_W-1:0];
    else                res = acc[DATA_W-1:0];
`else
    res = acc[DATA_W-1:0];
`endif
  end
endmodule

// File: rtl/slice_engine_param.sv
// Self-sequencing virtualised sigma-delta filter slice: one start sweeps all slots through a 4-stage pipeline.
// Build option SLICE_SAT_EN selects clamping of overflowed results (default: two's-complement wrap).
//   state | meaning
//   CLEAR | zero state[0..N-1], one word per cycle
//   IDLE  | wait for start, read-back port live
//   SWEEP | issue slot cnt to the pipeline
//   DRAIN | let the last three slots leave the pipeline
module slice_engine_param
  import slice_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int NUM_SLOTS = 16,
  parameter int COEF_AW   = 9,
  parameter int SHIFT     = 6
) (
  input  logic                         clock_200,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [COEF_AW-1:0]           coef_base,
  input  logic [NUM_SLOTS-1:0]         ff_bits,
  input  logic [NUM_SLOTS-1:0]         fb_bits,
  input  logic                         coef_wr_en,
  input  logic [COEF_AW-1:0]           coef_wr_adr,
  input  logic [2*COEF_W-1:0]          coef_wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         out_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] out_slot,
  output logic [DATA_W-1:0]            out_data,
  output logic                         ovf_sticky,
  input  logic                         ovf_clear,
  input  logic [$clog2(NUM_SLOTS)-1:0] rb_adr,
  output logic [DATA_W-1:0]            rb_data
);
  localparam int SW = $clog2(NUM_SLOTS);

  slice_state_e state, state_n;
  logic [SW-1:0] cnt, cnt_n;
  logic rst_hold, accept, issue, clr_we;

  logic [2*COEF_W-1:0]      coef_ram [2**COEF_AW];
  logic signed [DATA_W-1:0] state_ram [NUM_SLOTS];

  logic [COEF_AW-1:0]       base_q;
  logic [NUM_SLOTS-1:0]     ff_q, fb_q;
  logic                     v1, v2, ff1, fb1, sum_ovf;
  logic [SW-1:0]            slot1, slot2;
  logic [2*COEF_W-1:0]      coef_q;
  logic signed [DATA_W-1:0] st_q, res2, res2_sh, prev, sum;

  assign busy = (state != IDLE) && !rst_hold;

  // Reset parks the FSM in CLEAR for one held cycle so busy stays low during reset.
  always_ff @(posedge clock_200) begin
    if (!reset_n) begin
      state    <= CLEAR;
      cnt      <= '0;
      rst_hold <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rst_hold <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    issue   = 1'b0;
    clr_we  = 1'b0;
    if (!rst_hold) begin
      case (state)
        CLEAR: begin
          clr_we = 1'b1;
          if (cnt == SW'(NUM_SLOTS - 1)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + SW'(1);
          end
        end
        IDLE: begin
          if (start) begin
            accept  = 1'b1;
            state_n = SWEEP;
            cnt_n   = '0;
          end
        end
        SWEEP: begin
          issue = 1'b1;
          if (cnt == SW'(NUM_SLOTS - 1)) begin
            state_n = DRAIN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + SW'(1);
          end
        end
        DRAIN: begin
          if (cnt == SW'(2)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + SW'(1);
          end
        end
        default: state_n = CLEAR;
      endcase
    end
  end

  // Read-before-write: a coef read of the address being written sees the old word.
  always_ff @(posedge clock_200) begin
    if (coef_wr_en) coef_ram[coef_wr_adr] <= coef_wr_data;
    coef_q <= coef_ram[base_q + COEF_AW'(cnt)];
    st_q   <= state_ram[cnt];
    if (clr_we)  state_ram[cnt]   <= '0;
    else if (v2) state_ram[slot2] <= res2;
  end

  assign res2_sh = res2 >>> SHIFT;
  assign prev    = (v2 && slot1 != '0) ? res2_sh : '0;

  slice_sat_addsub #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_addsub (
    .prev  (prev),
    .st    (st_q),
    .coef_a(coef_q[2*COEF_W-1:COEF_W]),
    .coef_b(coef_q[COEF_W-1:0]),
    .add_a (ff1),
    .add_b (fb1),
    .res   (sum),
    .ovf   (sum_ovf)
  );

  always_ff @(posedge clock_200) begin
    if (!reset_n) begin
      base_q     <= '0;
      ff_q       <= '0;
      fb_q       <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      slot1      <= '0;
      slot2      <= '0;
      ff1        <= 1'b0;
      fb1        <= 1'b0;
      res2       <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      out_slot   <= '0;
      out_data   <= '0;
      ovf_sticky <= 1'b0;
      rb_data    <= '0;
    end else begin
      if (accept) begin
        base_q <= coef_base;
        ff_q   <= ff_bits;
        fb_q   <= fb_bits;
      end
      v1        <= issue;
      slot1     <= cnt;
      ff1       <= ff_q[cnt];
      fb1       <= fb_q[cnt];
      v2        <= v1;
      slot2     <= slot1;
      res2      <= sum;
      out_valid <= v2;
      done      <= v2 && (slot2 == SW'(NUM_SLOTS - 1));
      if (v2) begin
        out_slot <= slot2;
        out_data <= res2_sh;
      end
      if (v1 && sum_ovf) ovf_sticky <= 1'b1;
      else if (ovf_clear) ovf_sticky <= 1'b0;
      if (!busy) rb_data <= state_ram[rb_adr];
    end
  end
endmodule
